// File: rtl/fm_synth_pkg.sv
// fm_synth_pkg: shared types and helpers for the FM voice engine.
//   fm_state_e : slot sequencer states (idle, issue, wait, capture, done)
//   idx_w      : index width for a count of n items (never below 1)
//   sat_add    : signed add clamped to a w-bit two's-complement range
package fm_synth_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapture,
    StDone
  } fm_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operands are pre-extended to 64 bits so the raw sum cannot overflow.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/fm_phase_bank.sv
// fm_phase_bank: DEPTH x NUM_BITS phase accumulator array.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears every entry)
//   i_idx          : entry addressed this cycle (read and write share it)
//   i_we, i_wdata  : write strobe and new accumulator value
//   o_rdata        : current value of entry i_idx (combinational read)
module fm_phase_bank #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned IDX_W    = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_we,
  input  logic [NUM_BITS-1:0] i_wdata,
  output logic [NUM_BITS-1:0] o_rdata
);

  logic [NUM_BITS-1:0] r_acc [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_acc[i] <= '0;
    end else if (i_we) begin
      r_acc[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_acc[i_idx];

endmodule

// File: rtl/fm_voice_engine.sv
// fm_voice_engine: time-multiplexed FM core, NUM_OPS chained operators per voice, NUM_CHANNELS
// voices per frame, one shared cos LUT, saturating sum of carriers to a single DAC word.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_frame_start        : pulse that starts a frame; o_overrun pulses if it arrives while busy
//   i_tuning, i_note_en  : per-(voice,op) tuning words, per-voice gate
//   i_mod_depth          : unsigned modulation index shared by all operators
//   o_lut_addr, o_lut_rd : LUT read request; i_lut_data returns LUT_LATENCY cycles later
//   o_sample_out         : frame sum, held; o_sample_valid pulses in the cycle it updates
//   o_busy               : high from accepted frame_start through the sample_valid cycle
// Build option FM_FEEDBACK_EN: adds i_fb_depth and per-voice self-feedback on the top operator.
module fm_voice_engine
  import fm_synth_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 16,
  parameter int unsigned NUM_OPS       = 2,
  parameter int unsigned NUM_BITS      = 32,
  parameter int unsigned LUT_ADDR_BITS = 15,
  parameter int unsigned SAMPLE_BITS   = 18,
  parameter int unsigned ACC_BITS      = 24,
  parameter int unsigned LUT_LATENCY   = 2,
  parameter int unsigned MOD_SHIFT     = 6
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_frame_start,
  input  logic [NUM_CHANNELS*NUM_OPS*NUM_BITS-1:0] i_tuning,
  input  logic [NUM_CHANNELS-1:0]                 i_note_en,
  input  logic [7:0]                              i_mod_depth,
`ifdef FM_FEEDBACK_EN
  input  logic [2:0]                              i_fb_depth,
`endif
  output logic [LUT_ADDR_BITS-1:0]                o_lut_addr,
  output logic                                    o_lut_rd,
  input  logic signed [SAMPLE_BITS-1:0]           i_lut_data,
  output logic signed [ACC_BITS-1:0]              o_sample_out,
  output logic                                    o_sample_valid,
  output logic                                    o_busy,
  output logic                                    o_overrun
);

  localparam int unsigned NUM_SLOTS = NUM_CHANNELS * NUM_OPS;
  localparam int unsigned CH_W      = idx_w(NUM_CHANNELS);
  localparam int unsigned OP_W      = idx_w(NUM_OPS);
  localparam int unsigned SLOT_W    = idx_w(NUM_SLOTS);
  localparam int unsigned WAIT_W    = idx_w(LUT_LATENCY);
  localparam int unsigned TUN_W     = idx_w(NUM_SLOTS * NUM_BITS);

  fm_state_e r_state, w_state_next;

  logic [CH_W-1:0]               r_ch;
  logic [OP_W-1:0]               r_op;
  logic [WAIT_W-1:0]             r_wait;
  logic                          r_voice_en;
  logic signed [SAMPLE_BITS-1:0] r_op_out;
  logic signed [ACC_BITS-1:0]    r_sum;
  logic signed [ACC_BITS-1:0]    r_sample_out;

  logic [SLOT_W-1:0]             w_slot;
  logic [TUN_W-1:0]              w_tun_base;
  logic                          w_top_op, w_last_ch, w_last_slot, w_wait_done, w_voice_en;
  logic signed [SAMPLE_BITS-1:0] w_prev_out;
  logic signed [SAMPLE_BITS+8:0] w_prod;
  logic [NUM_BITS-1:0]           w_mod, w_acc_rd, w_acc_wdata;
  logic                          w_acc_we;
  logic signed [ACC_BITS-1:0]    w_sum_next;

  assign w_slot      = SLOT_W'(r_ch * NUM_OPS + r_op);
  assign w_tun_base  = TUN_W'(w_slot * NUM_BITS);
  assign w_top_op    = (r_op == OP_W'(NUM_OPS - 1));
  assign w_last_ch   = (r_ch == CH_W'(NUM_CHANNELS - 1));
  assign w_last_slot = w_last_ch && (r_op == '0);
  assign w_wait_done = (r_wait == WAIT_W'(LUT_LATENCY - 1));
  // Voice gate is sampled at the voice's first (top-op) slot and held for the rest of its ops.
  assign w_voice_en  = w_top_op ? i_note_en[r_ch] : r_voice_en;

`ifdef FM_FEEDBACK_EN
  logic signed [SAMPLE_BITS-1:0] r_fb [NUM_CHANNELS];
  logic signed [SAMPLE_BITS-1:0] w_fb_scaled;
  assign w_fb_scaled = (i_fb_depth == 3'd0) ? '0 : (r_fb[r_ch] >>> (3'd7 - i_fb_depth));
  assign w_prev_out  = w_top_op ? w_fb_scaled : r_op_out;
`else
  assign w_prev_out  = w_top_op ? '0 : r_op_out;
`endif

  // Signed sample times non-negative depth, sign-extended to the phase width, then shifted.
  assign w_prod      = w_prev_out * $signed({1'b0, i_mod_depth});
  assign w_mod       = NUM_BITS'(w_prod) << MOD_SHIFT;
  assign w_acc_wdata = w_voice_en ? (w_acc_rd + i_tuning[w_tun_base +: NUM_BITS]) : '0;
  assign w_sum_next  = ((r_op == '0) && r_voice_en)
                     ? ACC_BITS'(sat_add(64'(r_sum), 64'(r_op_out), ACC_BITS)) : r_sum;

  fm_phase_bank #(
    .DEPTH   (NUM_SLOTS),
    .NUM_BITS(NUM_BITS),
    .IDX_W   (SLOT_W)
  ) u_phase_bank (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_idx  (w_slot),
    .i_we   (w_acc_we),
    .i_wdata(w_acc_wdata),
    .o_rdata(w_acc_rd)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    o_lut_rd       = 1'b0;
    o_lut_addr     = '0;
    o_sample_valid = 1'b0;
    w_acc_we       = 1'b0;
    unique case (r_state)
      StIdle:    if (i_frame_start) w_state_next = StIssue;
      StIssue: begin
        o_lut_rd     = 1'b1;
        o_lut_addr   = LUT_ADDR_BITS'((w_acc_rd + w_mod) >> (NUM_BITS - LUT_ADDR_BITS));
        w_acc_we     = 1'b1;
        w_state_next = StWait;
      end
      StWait:    if (w_wait_done) w_state_next = StCapture;
      StCapture: w_state_next = w_last_slot ? StDone : StIssue;
      StDone: begin
        o_sample_valid = 1'b1;
        w_state_next   = StIdle;
      end
      default:   w_state_next = StIdle;
    endcase
  end

  assign o_busy       = (r_state != StIdle);
  assign o_overrun    = i_frame_start && o_busy;
  assign o_sample_out = r_sample_out;

  // LUT data is taken in the last wait cycle, exactly LUT_LATENCY cycles after the read.
  // The final sum lands in sample_out on entry to DONE so it is visible with sample_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ch         <= '0;
      r_op         <= OP_W'(NUM_OPS - 1);
      r_wait       <= '0;
      r_voice_en   <= 1'b0;
      r_op_out     <= '0;
      r_sum        <= '0;
      r_sample_out <= '0;
    end else begin
      case (r_state)
        StIssue: begin
          r_wait <= '0;
          if (w_top_op) r_voice_en <= i_note_en[r_ch];
        end
        StWait: begin
          r_wait <= r_wait + WAIT_W'(1);
          if (w_wait_done) r_op_out <= i_lut_data;
        end
        StCapture: begin
          if (w_last_slot) begin
            r_sample_out <= w_sum_next;
            r_sum        <= '0;
          end else begin
            r_sum <= w_sum_next;
          end
          if (r_op == '0) begin
            r_op <= OP_W'(NUM_OPS - 1);
            r_ch <= w_last_ch ? '0 : r_ch + CH_W'(1);
          end else begin
            r_op <= r_op - OP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FM_FEEDBACK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) r_fb[i] <= '0;
    end else if ((r_state == StCapture) && w_top_op) begin
      r_fb[r_ch] <= r_voice_en ? r_op_out : '0;
    end
  end
`endif

endmodule

// File: tb/tb_fm_voice_engine.sv
// tb_fm_voice_engine: randomized and directed frames against a frame-level reference model.
// A small latency-2 LUT model answers reads; every LUT address, frame latency and frame sum is
// compared with values computed by the model from the arithmetic rules of the engine.
module tb_fm_voice_engine;
  localparam int unsigned NCH = 4;
  localparam int unsigned NOPS = 2;
  localparam int unsigned NB = 32;
  localparam int unsigned LAB = 15;
  localparam int unsigned SB = 18;
  localparam int unsigned AB = 19;
  localparam int unsigned LL = 2;
  localparam int unsigned MS = 6;
  localparam int LAT = NCH * NOPS * (LL + 2) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_start;
  logic [NCH*NOPS*NB-1:0] tuning;
  logic [NCH-1:0] note_en;
  logic [7:0] mod_depth;
  logic [LAB-1:0] lut_addr;
  logic lut_rd;
  logic signed [SB-1:0] lut_data;
  logic signed [AB-1:0] sample_out;
  logic sample_valid, busy, overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fm_voice_engine #(
    .NUM_CHANNELS (NCH),
    .NUM_OPS      (NOPS),
    .NUM_BITS     (NB),
    .LUT_ADDR_BITS(LAB),
    .SAMPLE_BITS  (SB),
    .ACC_BITS     (AB),
    .LUT_LATENCY  (LL),
    .MOD_SHIFT    (MS)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_start (frame_start),
    .i_tuning      (tuning),
    .i_note_en     (note_en),
    .i_mod_depth   (mod_depth),
`ifdef FM_FEEDBACK_EN
    .i_fb_depth    (3'd0),
`endif
    .o_lut_addr    (lut_addr),
    .o_lut_rd      (lut_rd),
    .i_lut_data    (lut_data),
    .o_sample_out  (sample_out),
    .o_sample_valid(sample_valid),
    .o_busy        (busy),
    .o_overrun     (overrun)
  );

  // LUT content: a constant, or an address hash spanning the full signed range.
  int lut_mode = 0;
  logic signed [SB-1:0] lut_const = '0;

  function automatic logic signed [SB-1:0] lut_f(input logic [LAB-1:0] a);
    logic [SB-1:0] t;
    if (lut_mode == 0) return lut_const;
    t = {a, 3'b101} ^ 18'h15A5A;
    return $signed(t);
  endfunction

  // Data is valid exactly LL cycles after the read, then replaced by junk.
  logic signed [SB-1:0] lut_stage;
  logic lut_stage_v = 1'b0;
  always @(posedge clk) begin
    lut_stage   <= lut_f(lut_addr);
    lut_stage_v <= lut_rd;
    lut_data    <= lut_stage_v ? lut_stage : 18'sh2AAAA;
  end

  // Reference model state
  logic [NB-1:0] macc [NCH][NOPS];
  logic [LAB-1:0] exp_q[$];
  longint exp_sum;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++)
      for (int o = 0; o < NOPS; o++) macc[c][o] = '0;
  endtask

  task automatic model_frame();
    longint sum, lo, hi;
    lo = -(longint'(1) <<< (AB - 1));
    hi = (longint'(1) <<< (AB - 1)) - 1;
    sum = 0;
    exp_q.delete();
    for (int c = 0; c < NCH; c++) begin
      bit en;
      longint prev;
      en   = note_en[c];
      prev = 0;
      for (int o = NOPS - 1; o >= 0; o--) begin
        logic [NB-1:0] ph;
        logic [LAB-1:0] a;
        longint smp;
        ph = macc[c][o] + NB'(prev * longint'(mod_depth) * (longint'(1) <<< MS));
        a = ph[NB-1 -: LAB];
        exp_q.push_back(a);
        smp = longint'(lut_f(a));
        macc[c][o] = en ? macc[c][o] + tuning[(c*NOPS+o)*NB +: NB] : '0;
        prev = smp;
        if (o == 0 && en) begin
          sum = sum + smp;
          if (sum > hi) sum = hi;
          if (sum < lo) sum = lo;
        end
      end
    end
    exp_sum = sum;
  endtask

  // Run one frame; inj>0 re-pulses frame_start in that cycle of the frame.
  task automatic run_frame(input int inj);
    bit seen;
    model_frame();
    @(negedge clk);
    frame_start = 1'b1;
    #1;
    check("start_no_overrun", overrun, 0);
    check("start_idle", busy, 0);
    seen = 1'b0;
    for (int n = 1; n <= LAT + 4 && !seen; n++) begin
      @(negedge clk);
      frame_start = (n == inj);
      #1;
      if (n == inj) check("overrun_pulse", overrun, 1);
      else if (overrun) check("overrun_spurious", overrun, 0);
      if (n == 2) check("busy_run", busy, 1);
      if (lut_rd) begin
        if (exp_q.size() == 0) check("extra_lut_rd", 1, 0);
        else check("lut_addr", lut_addr, exp_q.pop_front());
      end
      if (sample_valid) begin
        seen = 1'b1;
        check("latency", n, LAT);
        check("sample_out", sample_out, exp_sum);
      end
    end
    frame_start = 1'b0;
    if (!seen) check("valid_timeout", 0, 1);
    check("rd_count", exp_q.size(), 0);
    @(negedge clk);
    #1;
    check("busy_drop", busy, 0);
    check("valid_single", sample_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    tuning = '0;
    note_en = '0;
    mod_depth = '0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    check("rst_sample_out", sample_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_lut_rd", lut_rd, 0);
    check("rst_lut_addr", lut_addr, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single voice, carrier tuned 2^28, no modulation, constant LUT
    note_en = 4'b0001;
    tuning[0 +: NB] = 32'h1000_0000;
    lut_const = 18'sd1000;
    for (int f = 0; f < 4; f++) begin
      run_frame(0);
      check("const_sample", sample_out, 1000);
    end

    // Saturation both ways with every voice on
    note_en = '1;
    lut_const = 18'sd131071;
    run_frame(0);
    check("sat_pos", sample_out, 262143);
    lut_const = 18'h20000;
    run_frame(0);
    check("sat_neg", sample_out, -262144);

    // Modulator output -1 at depth 1 pulls the carrier phase back by 2^MS
    note_en = 4'b0011;
    mod_depth = 8'd1;
    lut_const = -18'sd1;
    tuning = '0;
    tuning[0 +: NB] = 32'h0123_4567;
    tuning[NB +: NB] = 32'h0765_4321;
    run_frame(0);
    run_frame(0);

    // Overrun mid-frame and in the done cycle
    lut_mode = 1;
    mod_depth = 8'd37;
    run_frame(5);
    run_frame(LAT);

    // Reset in the middle of a wait
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_lut_rd", lut_rd, 0);
    check("arst_sample_out", sample_out, 0);
    check("arst_valid", sample_valid, 0);
    begin
      bit any_valid;
      any_valid = 1'b0;
      for (int k = 0; k < LAT + 2; k++) begin
        @(negedge clk);
        if (sample_valid) any_valid = 1'b1;
      end
      check("arst_no_valid", any_valid, 0);
    end
    rst_n = 1'b1;
    model_clear();
    run_frame(0);

    // Randomized frames
    for (int r = 0; r < 20; r++) begin
      for (int s = 0; s < NCH * NOPS; s++) tuning[s*NB +: NB] = $urandom;
      note_en   = NCH'($urandom);
      mod_depth = 8'($urandom);
      lut_mode  = int'($urandom_range(0, 1));
      lut_const = SB'($urandom);
      run_frame((r % 4 == 3) ? int'($urandom_range(1, LAT)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
